ov_sccb_target: RTL

- SCCB target (camera-side responder) for the OmniVision-style SCCB initiator.
- Decodes 3-phase write, 2-phase write and 2-phase read cycles from sio_c/sio_d/sccb_e.
- Exposes a simple register-file port.
- Used as an on-chip camera model for bench/loopback verification, and for FPGA boards that emulate a camera register map.

---
 rtl/ov_sccb_target_if.sv | 25 ++
 rtl/ov_sccb_target.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ov_sccb_target_if.sv
// SCCB pad-level bus between an initiator (master) and a camera-side target (slave).
// sio_d_i is the resolved line as seen at the pad; the target drives via sio_d_o/sio_d_oe.
interface ov_sccb_target_if;
    logic sccb_e;
    logic sio_c;
    logic sio_d_i;
    logic sio_d_o;
    logic sio_d_oe;

    modport master (
        output sccb_e,
        output sio_c,
        output sio_d_i,
        input  sio_d_o,
        input  sio_d_oe
    );

    modport slave (
        input  sccb_e,
        input  sio_c,
        input  sio_d_i,
        output sio_d_o,
        output sio_d_oe
    );
endinterface

// File: rtl/ov_sccb_target.sv
// SCCB camera-side target: decodes 3-phase write, 2-phase write and 2-phase read
// cycles and exposes a simple register-file port. The target never drives an ACK.
module ov_sccb_target #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    ov_sccb_target_if.slave     bus,
    output logic [7:0]          reg_addr,
    output logic [7:0]          reg_wdata,
    output logic                reg_we,
    output logic                reg_re,
    input  logic [7:0]          reg_rdata,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        ID,
        SUB,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic [1:0]             load_pipe;
    logic [SYNC_STAGES-1:0] sc_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   sc_prev;
    logic                   sd_prev;

    logic sc_s;
    logic sd_s;
    logic en_s;
    logic sc_rise;
    logic sc_fall;
    logic start_cond;
    logic stop_cond;
    logic [7:0] next_byte;

    assign sc_s       = sc_sync[SYNC_STAGES-1];
    assign sd_s       = sd_sync[SYNC_STAGES-1];
    assign en_s       = en_sync[SYNC_STAGES-1];
    assign sc_rise    = sc_s & ~sc_prev;
    assign sc_fall    = ~sc_s & sc_prev;
    assign start_cond = sc_s & sd_prev & ~sd_s;
    assign stop_cond  = sc_s & ~sd_prev & sd_s;
    assign next_byte  = {shift[6:0], sd_s};

    // Idle-high fill keeps a released bus from looking like a START after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sc_sync <= '1;
            sd_sync <= '1;
            en_sync <= '1;
            sc_prev <= 1'b1;
            sd_prev <= 1'b1;
        end else begin
            sc_sync <= {sc_sync[SYNC_STAGES-2:0], bus.sio_c};
            sd_sync <= {sd_sync[SYNC_STAGES-2:0], bus.sio_d_i};
            en_sync <= {en_sync[SYNC_STAGES-2:0], bus.sccb_e};
            sc_prev <= sc_s;
            sd_prev <= sd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            load_pipe <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            bus.sio_d_o  <= 1'b0;
            bus.sio_d_oe <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= (state != IDLE);
            // Read data arrives one clk after reg_re, i.e. two clks after the decision.
            load_pipe <= {load_pipe[0], 1'b0};
            if (load_pipe[1]) begin
                shift <= reg_rdata;
            end

            if (en_s) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                load_pipe    <= '0;
                bus.sio_d_oe <= 1'b0;
            end else if (start_cond) begin
                state        <= ID;
                bit_cnt      <= '0;
                err          <= 1'b0;
                load_pipe    <= '0;
                bus.sio_d_oe <= 1'b0;
            end else if (stop_cond) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                load_pipe    <= '0;
                bus.sio_d_oe <= 1'b0;
            end else begin
                case (state)
                    ID, SUB, WDATA: begin
                        if (sc_rise) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                if (state == ID) begin
                                    if (shift[7:1] != DEV_ID[7:1]) begin
                                        state <= IGNORE;
                                        err   <= 1'b1;
                                    end else if (shift[0]) begin
                                        state     <= RDATA;
                                        reg_re    <= 1'b1;
                                        load_pipe <= 2'b01;
                                    end else begin
                                        state <= SUB;
                                    end
                                end else if (state == SUB) begin
                                    state <= WDATA;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                shift   <= next_byte;
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd7 && state == SUB) begin
                                    reg_addr <= next_byte;
                                end
                                if (bit_cnt == 4'd7 && state == WDATA) begin
                                    reg_wdata <= next_byte;
                                    reg_we    <= 1'b1;
                                end
                            end
                        end
                    end
                    // Eight falls drive data, the ninth releases the line for the NA bit.
                    RDATA: begin
                        if (sc_fall) begin
                            if (bit_cnt != 4'd8) begin
                                bus.sio_d_oe <= 1'b1;
                                bus.sio_d_o  <= shift[7];
                                shift        <= {shift[6:0], 1'b0};
                                bit_cnt      <= bit_cnt + 4'd1;
                            end else begin
                                bus.sio_d_oe <= 1'b0;
                            end
                        end else if (sc_rise && bit_cnt == 4'd8 && !bus.sio_d_oe) begin
                            state   <= IGNORE;
                            bit_cnt <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
